instr_mem_ctrl: RTL and testbench
=================================

// Module: instr_mem_ctrl
// PURPOSE
//   Parametrised instruction memory with a built-in boot-loader sequencer.
//   After reset it accepts a program stream on the load port and writes it at
//   auto-incrementing addresses, then switches to RUN. In RUN it serves
//   registered, one-cycle-latency fetches to the core. Fetches above the
//   loaded region are flagged and return NOP_WORD.
// PARAMETERS
//   ADDR_W   9             word-address width
//   DATA_W   32            instruction width
//   DEPTH    2**ADDR_W     number of words; must be <= 2**ADDR_W
//   NOP_WORD 32'h0000_0000 word returned on an out-of-range fetch
// PORTS
//   clk         in   1         single clock, rising edge
//   rst         in   1         synchronous, active-high reset
//   ld_start    in   1         restart loading from address 0
//   ld_valid    in   1         ld_data valid this cycle (write strobe)
//   ld_data     in   DATA_W    program word to write
//   ld_done     in   1         host marks end of program
//   f_req       in   1         fetch request (RUN only)
//   f_addr      in   ADDR_W    fetch word address
//   f_valid     out  1         f_instr/f_err valid (1 cycle after f_req)
//   f_instr     out  DATA_W    fetched instruction
//   f_err       out  1         fetch address was >= word_count
//   ready       out  1         1 in RUN, 0 in LOAD
//   word_count  out  ADDR_W+1  number of words loaded so far
// BEHAVIOUR
//   - Reset (sync, active-high): state=LOAD, wr_ptr=0, word_count=0,
//     f_valid=0, f_instr=0, f_err=0, ready=0. Memory contents are not cleared.
//   - FSM has two states:
//     LOAD -> RUN on ld_done, or on the write that makes word_count==DEPTH.
//     RUN  -> LOAD on ld_start; this clears wr_ptr and word_count to 0.
//     ld_start in LOAD also clears wr_ptr/word_count and stays in LOAD.
//   - LOAD, ld_valid=1: mem[wr_ptr] <= ld_data, then wr_ptr++ and word_count++.
//   - ld_valid and ld_done in the same cycle: the word is written first,
//     then RUN is entered on the next cycle.
//   - ld_start together with ld_valid: ld_start wins and the data is dropped.
//   - ld_valid in RUN is ignored. Memory is never written in RUN.
//   - ready is driven combinationally from the state (==RUN).
//   - Fetch: f_req=1 in RUN at cycle N gives f_valid=1 at N+1, with:
//     f_addr <  word_count: f_instr=mem[f_addr], f_err=0
//     f_addr >= word_count: f_instr=NOP_WORD, f_err=1
//     The addr/count compare is zero-extended to ADDR_W+1 bits.
//   - Back-to-back fetches are allowed, one per cycle, with full throughput.
//   - f_req=0 gives f_valid=0 next cycle; f_instr and f_err hold their
//     last values.
//   - f_req in LOAD is dropped: f_valid=0 next cycle and no error is raised.
//   - f_req and ld_start in the same RUN cycle: the fetch is dropped
//     (f_valid=0 next cycle).
//   - A fetch accepted at cycle N still completes at N+1, even if ld_start
//     arrives at N+1.
//   - Reset mid-load: progress is abandoned, word_count=0, back in LOAD;
//     previously written words remain in memory but are out of range.
//   - word_count saturates at DEPTH and cannot wrap. wr_ptr never exceeds
//     DEPTH-1 because reaching DEPTH forces RUN.
// TESTING
//   1. Reset, load 4 words A0..A3 with ld_done on the 4th -> ready=1 next
//      cycle, word_count=4; fetch addr 2 -> next cycle f_valid=1,
//      f_instr=A2, f_err=0.
//   2. Fetch addr 4 and addr 511 after a 4-word load -> f_instr=NOP_WORD,
//      f_err=1 for each.
//   3. Stream DEPTH=512 words without ld_done -> RUN entered after word 511,
//      word_count=512; fetch 0 and 511 return the 1st and last words.
//   4. f_req on 3 consecutive cycles (addr 0,1,2) -> f_valid high for 3
//      consecutive cycles, in order, starting 1 cycle later; f_req during
//      LOAD -> f_valid stays 0.
//   5. In RUN, ld_start with f_req the same cycle -> no f_valid, ready=0,
//      word_count=0. Reload 2 words -> fetch addr 2 returns f_err=1.
//   6. Assert rst after 3 of 5 words are loaded -> state LOAD, word_count=0,
//      f_valid/f_err=0. Reload succeeds from address 0.

Source files
------------

// File: rtl/instr_mem_ctrl.sv
// Instruction memory with a boot-loader sequencer: LOAD streams words in at
// auto-incrementing addresses, RUN serves registered one-cycle fetches.
module instr_mem_ctrl #(
    parameter int                ADDR_W   = 9,
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 2**ADDR_W,
    parameter logic [DATA_W-1:0] NOP_WORD = {DATA_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_start,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_done,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_valid,
    output logic [DATA_W-1:0] f_instr,
    output logic              f_err,
    output logic              ready,
    output logic [ADDR_W:0]   word_count
);

    typedef enum logic [0:0] {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   ONE_C    = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ONE_PTR  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   DEPTH_M1 = DEPTH_C - ONE_C;

    logic [DATA_W-1:0] mem_r [0:DEPTH-1];

    state_t            state_r;
    state_t            state_nx_s;
    logic [ADDR_W-1:0] wr_ptr_r;
    logic [ADDR_W:0]   word_count_r;
    logic              clr_s;
    logic              wr_en_s;
    logic              fetch_go_s;
    logic              in_range_s;

    // Next-state decode; ld_start has priority over any write or ld_done.
    always_comb begin
        state_nx_s = state_r;
        clr_s      = 1'b0;
        wr_en_s    = 1'b0;
        case (state_r)
            ST_LOAD: begin
                if (ld_start) begin
                    clr_s      = 1'b1;
                    state_nx_s = ST_LOAD;
                end else if (ld_valid) begin
                    wr_en_s = 1'b1;
                    if (ld_done || (word_count_r == DEPTH_M1)) begin
                        state_nx_s = ST_RUN;
                    end else begin
                        state_nx_s = ST_LOAD;
                    end
                end else if (ld_done) begin
                    state_nx_s = ST_RUN;
                end else begin
                    state_nx_s = ST_LOAD;
                end
            end
            ST_RUN: begin
                if (ld_start) begin
                    clr_s      = 1'b1;
                    state_nx_s = ST_LOAD;
                end else begin
                    state_nx_s = ST_RUN;
                end
            end
            default: begin
                state_nx_s = ST_LOAD;
            end
        endcase
    end

    // Fetch acceptance and range check against the loaded region.
    always_comb begin
        fetch_go_s = (state_r == ST_RUN) && f_req && !ld_start;
        in_range_s = ({1'b0, f_addr} < word_count_r);
    end

    // State, write pointer and word counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_LOAD;
            wr_ptr_r     <= {ADDR_W{1'b0}};
            word_count_r <= {(ADDR_W+1){1'b0}};
        end else begin
            state_r <= state_nx_s;
            if (clr_s) begin
                wr_ptr_r     <= {ADDR_W{1'b0}};
                word_count_r <= {(ADDR_W+1){1'b0}};
            end else if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + ONE_PTR;
                if (word_count_r != DEPTH_C) begin
                    word_count_r <= word_count_r + ONE_C;
                end
            end
        end
    end

    // Program storage; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= ld_data;
        end
    end

    // Registered fetch response; data and error hold when no fetch completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            f_valid <= 1'b0;
            f_instr <= {DATA_W{1'b0}};
            f_err   <= 1'b0;
        end else begin
            f_valid <= fetch_go_s;
            if (fetch_go_s) begin
                if (in_range_s) begin
                    f_instr <= mem_r[f_addr];
                    f_err   <= 1'b0;
                end else begin
                    f_instr <= NOP_WORD;
                    f_err   <= 1'b1;
                end
            end
        end
    end

    assign ready      = (state_r == ST_RUN);
    assign word_count = word_count_r;

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// Scoreboard bench for instr_mem_ctrl: expected fetch results are queued
// when a request is driven and matched against f_valid responses.
module tb_instr_mem_ctrl;
    localparam int ADDR_W = 9;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 512;
    localparam logic [DATA_W-1:0] NOP = 32'h0000_0000;

    logic              clk = 1'b0;
    logic              rst, ld_start, ld_valid, ld_done, f_req;
    logic [DATA_W-1:0] ld_data;
    logic [ADDR_W-1:0] f_addr;
    logic              f_valid, f_err, ready;
    logic [DATA_W-1:0] f_instr;
    logic [ADDR_W:0]   word_count;

    instr_mem_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .NOP_WORD(NOP)) dut (
        .clk(clk), .rst(rst), .ld_start(ld_start), .ld_valid(ld_valid),
        .ld_data(ld_data), .ld_done(ld_done), .f_req(f_req), .f_addr(f_addr),
        .f_valid(f_valid), .f_instr(f_instr), .f_err(f_err), .ready(ready),
        .word_count(word_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0] instr;
        logic              err;
        int                cyc;
    } exp_t;

    exp_t              sb_q[$];
    exp_t              sb_e;
    logic [DATA_W-1:0] model_mem [0:DEPTH-1];
    int                model_count = 0;
    logic [DATA_W-1:0] last_instr;
    logic              last_err;
    int                cyc = 0;
    int                n_checks = 0;
    int                n_errors = 0;

    always @(posedge clk) cyc++;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_words(input int start, input int n, input logic [DATA_W-1:0] base, input bit done);
        for (int i = 0; i < n; i++) begin
            ld_valid = 1'b1;
            ld_data  = base + DATA_W'(start + i);
            ld_done  = done && (i == n - 1);
            model_mem[start + i] = ld_data;
            tick();
        end
        ld_valid = 1'b0;
        ld_done  = 1'b0;
        model_count = start + n;
    endtask

    task automatic fetch(input logic [ADDR_W-1:0] a, input bit accept);
        exp_t e;
        f_req  = 1'b1;
        f_addr = a;
        if (accept) begin
            if (int'(a) < model_count) begin
                e.instr = model_mem[a];
                e.err   = 1'b0;
            end else begin
                e.instr = NOP;
                e.err   = 1'b1;
            end
            e.cyc = cyc + 1;
            last_instr = e.instr;
            last_err   = e.err;
            sb_q.push_back(e);
        end
        tick();
    endtask

    // Response monitor: pop on f_valid, flag unexpected or missing responses.
    always @(negedge clk) begin
        if (f_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                check_val("unexpected_f_valid", 64'd1, 64'd0);
            end else begin
                sb_e = sb_q.pop_front();
                check_val("f_instr", 64'(f_instr), 64'(sb_e.instr));
                check_val("f_err", 64'(f_err), 64'(sb_e.err));
                check_val("f_latency", 64'(cyc), 64'(sb_e.cyc));
            end
        end else if (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            check_val("missing_f_valid", 64'd0, 64'd1);
            sb_e = sb_q.pop_front();
        end
    end

    initial begin
        rst = 1'b1; ld_start = 1'b0; ld_valid = 1'b0; ld_done = 1'b0;
        f_req = 1'b0; ld_data = 32'h0000_0000; f_addr = 9'd0;
        tick(); tick();
        rst = 1'b0;
        check_val("rst_ready", 64'(ready), 64'd0);
        check_val("rst_word_count", 64'(word_count), 64'd0);
        check_val("rst_f_valid", 64'(f_valid), 64'd0);
        check_val("rst_f_instr", 64'(f_instr), 64'd0);
        check_val("rst_f_err", 64'(f_err), 64'd0);

        // Four-word load terminated by ld_done on the last word.
        load_words(0, 4, 32'hA000_0000, 1'b1);
        check_val("t1_ready", 64'(ready), 64'd1);
        check_val("t1_word_count", 64'(word_count), 64'd4);
        fetch(9'd2, 1'b1);
        f_req = 1'b0;
        tick(); tick();
        check_val("hold_f_valid", 64'(f_valid), 64'd0);
        check_val("hold_f_instr", 64'(f_instr), 64'(last_instr));
        check_val("hold_f_err", 64'(f_err), 64'(last_err));

        // Out-of-range fetches, then three back-to-back in-range fetches.
        fetch(9'd4, 1'b1);
        fetch(9'd511, 1'b1);
        fetch(9'd0, 1'b1);
        fetch(9'd1, 1'b1);
        fetch(9'd2, 1'b1);
        f_req = 1'b0;
        tick(); tick();

        // ld_start with f_req in RUN: fetch dropped, back to LOAD.
        ld_start = 1'b1; f_req = 1'b1; f_addr = 9'd0;
        tick();
        ld_start = 1'b0; f_req = 1'b0;
        model_count = 0;
        check_val("t5_ready", 64'(ready), 64'd0);
        check_val("t5_word_count", 64'(word_count), 64'd0);
        check_val("t5_f_valid", 64'(f_valid), 64'd0);
        fetch(9'd1, 1'b0);
        f_req = 1'b0;
        check_val("load_fetch_f_valid", 64'(f_valid), 64'd0);
        check_val("load_fetch_f_err", 64'(f_err), 64'd0);
        load_words(0, 2, 32'hB000_0000, 1'b1);
        check_val("t5_reload_count", 64'(word_count), 64'd2);
        fetch(9'd1, 1'b1);
        fetch(9'd2, 1'b1);
        // Accepted fetch must still complete when ld_start follows it.
        fetch(9'd3, 1'b1);
        f_req = 1'b0; ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        model_count = 0;
        tick();
        check_val("restart_ready", 64'(ready), 64'd0);

        // Reset after three of five words.
        load_words(0, 3, 32'hC000_0000, 1'b0);
        check_val("t6_partial_count", 64'(word_count), 64'd3);
        check_val("t6_partial_ready", 64'(ready), 64'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_count = 0;
        check_val("t6_word_count", 64'(word_count), 64'd0);
        check_val("t6_ready", 64'(ready), 64'd0);
        check_val("t6_f_valid", 64'(f_valid), 64'd0);
        check_val("t6_f_err", 64'(f_err), 64'd0);
        load_words(0, 5, 32'hD000_0000, 1'b1);
        check_val("t6_reload_count", 64'(word_count), 64'd5);
        fetch(9'd0, 1'b1);
        fetch(9'd4, 1'b1);
        fetch(9'd5, 1'b1);
        f_req = 1'b0;
        tick(); tick();

        // Full-depth stream without ld_done.
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        model_count = 0;
        load_words(0, DEPTH - 1, 32'hE000_0000, 1'b0);
        check_val("t3_pre_ready", 64'(ready), 64'd0);
        check_val("t3_pre_count", 64'(word_count), 64'(DEPTH - 1));
        load_words(DEPTH - 1, 1, 32'hE000_0000, 1'b0);
        check_val("t3_ready", 64'(ready), 64'd1);
        check_val("t3_word_count", 64'(word_count), 64'(DEPTH));
        ld_valid = 1'b1; ld_data = 32'hDEAD_BEEF;
        tick();
        ld_valid = 1'b0;
        check_val("run_ld_ignored_count", 64'(word_count), 64'(DEPTH));
        fetch(9'd0, 1'b1);
        fetch(9'd511, 1'b1);
        fetch(9'd256, 1'b1);
        f_req = 1'b0;
        tick(); tick(); tick();

        check_val("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
